// File: rtl/rr_arbiter_mux.sv
// rr_arbiter_mux: N-channel registered mux with round-robin/fixed-priority arbitration and valid/ready handshake.
// Optional packet locking (in_last/out_last) is enabled by defining RRMUX_PKT_EN.
module rr_arbiter_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
`ifdef RRMUX_PKT_EN
    input  logic [CHANNELS-1:0]       in_last,
    output logic                      out_last,
`endif
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);
    logic [SEL_W-1:0] r_ptr, r_out_chan, w_grant, w_lock_chan;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid, w_load, w_any, w_xfer, w_lock;

    assign w_load = !r_out_valid | out_ready;
    assign w_any  = |in_valid;

    // Descending loops: the last match written is the highest-priority one.
    always_comb begin
        w_grant = '0;
        if (w_lock)
            w_grant = w_lock_chan;
        else if (mode) begin
            for (int i = CHANNELS - 1; i >= 0; i--)
                if (in_valid[SEL_W'(i)]) w_grant = SEL_W'(i);
        end else begin
            for (int k = CHANNELS; k >= 1; k--)
                if (in_valid[SEL_W'((int'(r_ptr) + k) % CHANNELS)])
                    w_grant = SEL_W'((int'(r_ptr) + k) % CHANNELS);
        end
    end

    always_comb begin
        in_ready          = '0;
        in_ready[w_grant] = w_load & w_any & rst_n;
    end

    assign w_xfer = in_valid[w_grant] & in_ready[w_grant];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= SEL_W'(CHANNELS - 1);
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_xfer) begin
            r_out_data  <= in_data[w_grant*WIDTH +: WIDTH];
            r_out_chan  <= w_grant;
            r_out_valid <= 1'b1;
            if (!mode) r_ptr <= w_grant;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef RRMUX_PKT_EN
    logic             r_lock, r_out_last;
    logic [SEL_W-1:0] r_lock_chan;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock      <= 1'b0;
            r_lock_chan <= '0;
            r_out_last  <= 1'b0;
        end else if (w_xfer) begin
            r_lock      <= !in_last[w_grant];
            r_lock_chan <= w_grant;
            r_out_last  <= in_last[w_grant];
        end
    end

    assign w_lock      = r_lock;
    assign w_lock_chan = r_lock_chan;
    assign out_last    = r_out_last;
`else
    assign w_lock      = 1'b0;
    assign w_lock_chan = '0;
`endif

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;
endmodule
